ctrl_sequencer: RTL and testbench



---
 rtl/ctrl_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_sequencer
// Description : Hardwired fetch/execute control unit. Sequences one datapath
//               step per clock and drives every strobe as a Moore output of
//               the registered step. Memory steps stall on mem_ready and
//               fault after MEM_TIMEOUT held cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        LOin,
  output logic        HIin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        fault,
  output logic        illegal
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);
  localparam logic [4:0] OP_ADD      = 5'b00011;

  localparam logic [3:0] S_RST   = 4'd0;
  localparam logic [3:0] S_F0    = 4'd1;
  localparam logic [3:0] S_F1    = 4'd2;
  localparam logic [3:0] S_F2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;
  localparam logic [3:0] S_FAULT = 4'd10;

  // Instruction classes: every opcode in a class shares one step sequence
  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_ALU  = 3'd1;
  localparam logic [2:0] C_IMM  = 3'd2;
  localparam logic [2:0] C_LD   = 3'd3;
  localparam logic [2:0] C_ST   = 3'd4;
  localparam logic [2:0] C_MD   = 3'd5;
  localparam logic [2:0] C_HALT = 3'd6;
  localparam logic [2:0] C_ILL  = 3'd7;

  function automatic logic [2:0] classify(input logic [4:0] op);
    case (op)
      5'b00000:                     return C_LD;
      5'b00010:                     return C_ST;
      5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000,
      5'b01001, 5'b01010, 5'b01011,
      5'b10011:                     return C_ALU;
      5'b01100, 5'b01101, 5'b01110: return C_IMM;
      5'b01111, 5'b10000:           return C_MD;
      5'b11010:                     return C_NOP;
      5'b11011:                     return C_HALT;
      default:                      return C_ILL;
    endcase
  endfunction

  logic [3:0] state;
  logic [3:0] next_state;
  logic [4:0] op_q;
  logic [2:0] cls_q;
  logic [7:0] wait_cnt;
  logic [2:0] ir_cls;
  logic       mem_step;
  logic       timeout_hit;
  logic       unused_ir;

  // Only the opcode field is decoded here; operand fields belong to the datapath
  assign unused_ir   = ^IR[26:0];
  assign ir_cls      = classify(IR[31:27]);
  assign mem_step    = (state == S_F1) ||
                       (state == S_T6 && cls_q == C_LD) ||
                       (state == S_T7 && cls_q == C_ST);
  assign timeout_hit = mem_step && !mem_ready && (wait_cnt + 8'd1 == TIMEOUT_LIM);

  // State register; clear overrides every other condition
  always_ff @(posedge clock) begin
    if (clear) state <= S_RST;
    else       state <= next_state;
  end

  // Latch the opcode as the instruction leaves F2 so execute steps stay Moore
  always_ff @(posedge clock) begin
    if (clear) begin
      op_q  <= 5'd0;
      cls_q <= C_NOP;
    end else if (state == S_F2) begin
      op_q  <= IR[31:27];
      cls_q <= ir_cls;
    end
  end

  // Wait counter counts held memory cycles and restarts on any other cycle
  always_ff @(posedge clock) begin
    if (clear)                       wait_cnt <= 8'd0;
    else if (mem_step && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
    else                             wait_cnt <= 8'd0;
  end

  // Next-state: step progression, with memory steps held or faulted on no ready
  always_comb begin
    next_state = state;
    case (state)
      S_RST: next_state = S_F0;
      S_F0:  next_state = S_F1;
      S_F1:  next_state = S_F2;
      S_F2: begin
        case (ir_cls)
          C_HALT:       next_state = S_HALT;
          C_NOP, C_ILL: next_state = S_F0;
          default:      next_state = S_T3;
        endcase
      end
      S_T3: next_state = S_T4;
      S_T4: next_state = S_T5;
      S_T5: next_state = (cls_q == C_LD || cls_q == C_ST || cls_q == C_MD) ? S_T6 : S_F0;
      S_T6: next_state = (cls_q == C_LD || cls_q == C_ST) ? S_T7 : S_F0;
      S_T7: next_state = S_F0;
      S_HALT:  next_state = S_HALT;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_RST;
    endcase
    if (mem_step && !mem_ready) next_state = timeout_hit ? S_FAULT : state;
  end

  // Output decode from the registered step and latched instruction class
  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; Write = 1'b0;
    IRin = 1'b0; Yin = 1'b0; ZLowIn = 1'b0; ZHighIn = 1'b0;
    ZLowOut = 1'b0; ZHighOut = 1'b0; LOin = 1'b0; HIin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; alu_op = 5'd0;
    run = !(state == S_HALT || state == S_FAULT);
    fault = (state == S_FAULT);
    illegal = (state == S_F2) && (ir_cls == C_ILL);
    case (state)
      S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      S_F1: begin ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_F2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        Yin = 1'b1;
        case (cls_q)
          C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; end
          C_MD:       begin Gra = 1'b1; Rout = 1'b1; end
          default:    begin Grb = 1'b1; Rout = 1'b1; end
        endcase
      end
      S_T4: begin
        ZLowIn = 1'b1;
        alu_op = op_q;
        case (cls_q)
          C_ALU:      begin Grc = 1'b1; Rout = 1'b1; end
          C_IMM:      Cout = 1'b1;
          C_LD, C_ST: begin Cout = 1'b1; alu_op = OP_ADD; end
          default:    begin Grb = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; end
        endcase
      end
      S_T5: begin
        ZLowOut = 1'b1;
        case (cls_q)
          C_LD, C_ST: MARin = 1'b1;
          C_MD:       LOin = 1'b1;
          default:    begin Gra = 1'b1; Rin = 1'b1; end
        endcase
      end
      S_T6: begin
        case (cls_q)
          C_LD:    begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:    begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          default: begin ZHighOut = 1'b1; HIin = 1'b1; end
        endcase
      end
      S_T7: begin
        if (cls_q == C_ST) Write = 1'b1;
        else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_sequencer
// Description : Self-checking bench for ctrl_sequencer. A table model lists
//               the strobe set of every step of each instruction; directed
//               and random instruction streams are compared cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_sequencer;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR = 32'd0;
  logic        mem_ready = 1'b0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin;
  logic ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin, Gra, Grb, Grc;
  logic Rin, Rout, BAout, Cout, run, fault, illegal;
  logic [4:0] alu_op;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  ctrl_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
    .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .LOin(LOin), .HIin(HIin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Cout(Cout), .alu_op(alu_op), .run(run),
    .fault(fault), .illegal(illegal)
  );

  logic [30:0] obs;
  assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
                Yin, ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin, Gra, Grb,
                Grc, Rin, Rout, BAout, Cout, alu_op, run, fault, illegal};

  localparam logic [30:0] B_ILL   = 31'h1 << 0;
  localparam logic [30:0] B_FLT   = 31'h1 << 1;
  localparam logic [30:0] B_RUN   = 31'h1 << 2;
  localparam logic [30:0] B_COUT  = 31'h1 << 8;
  localparam logic [30:0] B_BAOUT = 31'h1 << 9;
  localparam logic [30:0] B_ROUT  = 31'h1 << 10;
  localparam logic [30:0] B_RIN   = 31'h1 << 11;
  localparam logic [30:0] B_GRC   = 31'h1 << 12;
  localparam logic [30:0] B_GRB   = 31'h1 << 13;
  localparam logic [30:0] B_GRA   = 31'h1 << 14;
  localparam logic [30:0] B_HIIN  = 31'h1 << 15;
  localparam logic [30:0] B_LOIN  = 31'h1 << 16;
  localparam logic [30:0] B_ZHOUT = 31'h1 << 17;
  localparam logic [30:0] B_ZLOUT = 31'h1 << 18;
  localparam logic [30:0] B_ZHIN  = 31'h1 << 19;
  localparam logic [30:0] B_ZLIN  = 31'h1 << 20;
  localparam logic [30:0] B_YIN   = 31'h1 << 21;
  localparam logic [30:0] B_IRIN  = 31'h1 << 22;
  localparam logic [30:0] B_WRITE = 31'h1 << 23;
  localparam logic [30:0] B_READ  = 31'h1 << 24;
  localparam logic [30:0] B_MDROUT= 31'h1 << 25;
  localparam logic [30:0] B_MDRIN = 31'h1 << 26;
  localparam logic [30:0] B_MARIN = 31'h1 << 27;
  localparam logic [30:0] B_INCPC = 31'h1 << 28;
  localparam logic [30:0] B_PCIN  = 31'h1 << 29;
  localparam logic [30:0] B_PCOUT = 31'h1 << 30;

  localparam logic [30:0] V_RST   = B_RUN;
  localparam logic [30:0] V_F0    = B_PCOUT | B_MARIN | B_INCPC | B_ZLIN | B_RUN;
  localparam logic [30:0] V_F1    = B_ZLOUT | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [30:0] V_FAULT = B_FLT;

  // Expected step list of the current instruction
  logic [30:0] m_vec [0:7];
  bit          m_mem [0:7];
  int          m_n;
  bit          m_halt;

  function automatic logic [30:0] aluv(input logic [4:0] op);
    return {23'd0, op, 3'd0};
  endfunction

  task automatic push(input logic [30:0] v, input bit mem);
    m_vec[m_n] = v | B_RUN;
    m_mem[m_n] = mem;
    m_n++;
  endtask

  // Reference model: the step table for one opcode
  task automatic build_model(input logic [4:0] op);
    bit is_alu, is_imm, is_md, is_ld, is_st, is_nop, is_halt;
    is_alu  = op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd19};
    is_imm  = op inside {5'd12, 5'd13, 5'd14};
    is_md   = op inside {5'd15, 5'd16};
    is_ld   = (op == 5'd0);
    is_st   = (op == 5'd2);
    is_nop  = (op == 5'd26);
    is_halt = (op == 5'd27);
    m_n = 0;
    m_halt = is_halt;
    push(V_F0, 0);
    push(V_F1, 1);
    push(B_MDROUT | B_IRIN |
         ((is_alu | is_imm | is_md | is_ld | is_st | is_nop | is_halt) ? 31'd0 : B_ILL), 0);
    if (is_alu) begin
      push(B_GRB | B_ROUT | B_YIN, 0);
      push(B_GRC | B_ROUT | B_ZLIN | aluv(op), 0);
      push(B_ZLOUT | B_GRA | B_RIN, 0);
    end else if (is_imm) begin
      push(B_GRB | B_ROUT | B_YIN, 0);
      push(B_COUT | B_ZLIN | aluv(op), 0);
      push(B_ZLOUT | B_GRA | B_RIN, 0);
    end else if (is_ld || is_st) begin
      push(B_GRB | B_BAOUT | B_YIN, 0);
      push(B_COUT | B_ZLIN | aluv(5'd3), 0);
      push(B_ZLOUT | B_MARIN, 0);
      if (is_ld) begin
        push(B_READ | B_MDRIN, 1);
        push(B_MDROUT | B_GRA | B_RIN, 0);
      end else begin
        push(B_GRA | B_ROUT | B_MDRIN, 0);
        push(B_WRITE, 1);
      end
    end else if (is_md) begin
      push(B_GRA | B_ROUT | B_YIN, 0);
      push(B_GRB | B_ROUT | B_ZLIN | B_ZHIN | aluv(op), 0);
      push(B_ZLOUT | B_LOIN, 0);
      push(B_ZHOUT | B_HIIN, 0);
    end
  endtask

  // Runs one instruction from F0, comparing every cycle. Memory steps wait a
  // random number of cycles in [wlo, whi]. abort_at >= 0 pulses clear after
  // that step. Ends one cycle after the instruction, at the next F0.
  task automatic run_instr(input logic [4:0] op, input logic [26:0] low,
                           input int wlo, input int whi, input int abort_at,
                           input string name);
    int w;
    build_model(op);
    IR = {op, low};
    for (int i = 0; i < m_n; i++) begin
      w = m_mem[i] ? int'($urandom_range(whi, wlo)) : 0;
      for (int k = 0; k <= w; k++) begin
        n_checks++;
        if (obs !== m_vec[i]) begin
          n_fail++;
          $display("FAIL %s step %0d wait %0d: got %h expected %h", name, i, k, obs, m_vec[i]);
        end
        mem_ready = m_mem[i] ? (k == w) : 1'($urandom);
        if (i == abort_at) clear = 1'b1;
        @(posedge clock); #1;
        if (i == abort_at) begin
          clear = 1'b0;
          n_checks++;
          if (obs !== V_RST) begin
            n_fail++;
            $display("FAIL %s clear_to_rst: got %h expected %h", name, obs, V_RST);
          end
          @(posedge clock); #1;
          return;
        end
      end
    end
    if (m_halt) begin
      for (int c = 0; c < 20; c++) begin
        n_checks++;
        if (obs !== 31'd0) begin
          n_fail++;
          $display("FAIL %s halt cycle %0d: got %h expected %h", name, c, obs, 31'd0);
        end
        mem_ready = 1'($urandom);
        @(posedge clock); #1;
      end
    end
  endtask

  // Applies clear for one edge and checks RST, leaving the DUT entering F0
  task automatic do_reset(input string name);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    n_checks++;
    if (obs !== V_RST) begin
      n_fail++;
      $display("FAIL %s rst_state: got %h expected %h", name, obs, V_RST);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if (obs !== V_RST) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", c, obs, V_RST);
      end
    end
    clear = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (obs !== V_F0) begin
      n_fail++;
      $display("FAIL reset_to_f0: got %h expected %h", obs, V_F0);
    end
  endtask

  task automatic test_shla();
    logic [31:0] ir_v;
    ir_v = 32'h9A1B8000;
    do_reset("shla");
    run_instr(ir_v[31:27], ir_v[26:0], 0, 0, -1, "shla");
    n_checks++;
    if (obs !== V_F0) begin
      n_fail++;
      $display("FAIL shla_f0_at_cycle7: got %h expected %h", obs, V_F0);
    end
  endtask

  task automatic test_ld_wait();
    logic [31:0] ir_v;
    ir_v = 32'h00800055;
    run_instr(ir_v[31:27], ir_v[26:0], 3, 3, -1, "ld_wait");
  endtask

  task automatic test_timeout();
    do_reset("timeout");
    mem_ready = 1'b0;
    IR = 32'h18000000;
    n_checks++;
    if (obs !== V_F0) begin
      n_fail++;
      $display("FAIL timeout_f0: got %h expected %h", obs, V_F0);
    end
    @(posedge clock); #1;
    for (int c = 0; c < TIMEOUT; c++) begin
      n_checks++;
      if (obs !== V_F1) begin
        n_fail++;
        $display("FAIL timeout_f1_held cycle %0d: got %h expected %h", c, obs, V_F1);
      end
      @(posedge clock); #1;
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (obs !== V_FAULT) begin
        n_fail++;
        $display("FAIL timeout_fault cycle %0d: got %h expected %h", c, obs, V_FAULT);
      end
      mem_ready = 1'b1;
      @(posedge clock); #1;
    end
    do_reset("timeout_clear");
    n_checks++;
    if (obs !== V_F0) begin
      n_fail++;
      $display("FAIL timeout_refetch: got %h expected %h", obs, V_F0);
    end
  endtask

  task automatic test_mul_halt();
    run_instr(5'b01111, 27'($urandom), 0, 2, -1, "mul");
    run_instr(5'b10000, 27'($urandom), 0, 2, -1, "div");
    run_instr(5'b11011, 27'd0, 0, 0, -1, "halt");
    do_reset("halt_clear");
  endtask

  task automatic test_illegal();
    run_instr(5'b11111, 27'($urandom), 0, 1, -1, "illegal");
    n_checks++;
    if (obs !== V_F0) begin
      n_fail++;
      $display("FAIL illegal_next_f0: got %h expected %h", obs, V_F0);
    end
  endtask

  task automatic test_clear_mid_st();
    run_instr(5'b00010, 27'($urandom), 0, 0, 6, "st_clear");
    run_instr(5'b00010, 27'($urandom), 1, 3, -1, "st_refetch");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom_range(31, 0));
      if (op == 5'd27) op = 5'd26;
      run_instr(op, 27'($urandom), 0, 5, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_shla();
    test_ld_wait();
    test_timeout();
    test_mul_halt();
    test_illegal();
    test_clear_mid_st();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
